bin2bcd_channel_bank: RTL and testbench

- Produces the 13 packed-BCD channel words (4 digits, 16 bits each) that the VGA text-display path turns into ASCII and draws on screen.
- Accepts one binary measurement at a time from the acquisition sequencer over a valid/ready handshake.
- Converts each value with a sequential shift-add-3 (double-dabble) engine.
- Stores the result in a per-channel output register bank that drives the display inputs continuously.

---
 rtl/bin2bcd_channel_bank.sv | 162 ++++++++++++++++
 tb/tb_bin2bcd_channel_bank.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_channel_bank.sv
// Binary-to-BCD converter feeding a bank of per-channel packed-BCD display registers.
// Optional BIN2BCD_SCALE_MV_EN: treat in_data as an XADC word and scale it to 0..999 mV first.

module bin2bcd_chan_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [15:0] d,
  output logic [15:0] q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= '0;
    else if (we) q <= d;
  end
endmodule

module bin2bcd_channel_bank #(
  parameter int CHANNELS = 13,
  parameter int MAX_VAL  = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_ch,
  input  logic [15:0] in_data,
  output logic        done,
  output logic        sat,
  output logic        err,
  output logic [15:0] out0,
  output logic [15:0] out1,
  output logic [15:0] out2,
  output logic [15:0] out3,
  output logic [15:0] out4,
  output logic [15:0] out5,
  output logic [15:0] out6,
  output logic [15:0] out7,
  output logic [15:0] out8,
  output logic [15:0] out9,
  output logic [15:0] out10,
  output logic [15:0] out11,
  output logic [15:0] out12
);
  localparam int              NUM_PORTS = 13;
  localparam logic [4:0]      CH_LIM    = 5'(CHANNELS);
  localparam logic [15:0]     MAX_V     = 16'(MAX_VAL);

  typedef enum logic [1:0] {IDLE, MUL, SHIFT, STORE} state_t;

  state_t      state;
  logic [15:0] bcd, bin, bcd_adj;
  logic [3:0]  cnt, ch_q;
  logic        sat_q;
  logic        ch_oob, wr_en;
  logic [15:0] bank [NUM_PORTS];

  assign ch_oob = {1'b0, ch_q} >= CH_LIM;
  assign wr_en  = (state == STORE) && !ch_oob;

  // Double-dabble correction: any digit >= 5 would carry wrong after doubling.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
  end

`ifdef BIN2BCD_SCALE_MV_EN
  // 12-bit code * 1000 fits in 22 bits; the top 10 bits are the millivolt value.
  logic [9:0] mv;
  assign mv = 10'(({10'd0, bin[15:4]} * 22'd1000) >> 12);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      done     <= 1'b0;
      sat      <= 1'b0;
      err      <= 1'b0;
      bcd      <= '0;
      bin      <= '0;
      cnt      <= '0;
      ch_q     <= '0;
      sat_q    <= 1'b0;
    end else begin
      done <= 1'b0;
      sat  <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            ch_q     <= in_ch;
            bcd      <= '0;
            cnt      <= '0;
`ifdef BIN2BCD_SCALE_MV_EN
            bin      <= in_data;
            sat_q    <= 1'b0;
            state    <= MUL;
`else
            bin      <= (in_data > MAX_V) ? MAX_V : in_data;
            sat_q    <= in_data > MAX_V;
            state    <= SHIFT;
`endif
          end else begin
            in_ready <= 1'b1;
          end
        end
`ifdef BIN2BCD_SCALE_MV_EN
        MUL: begin
          bin   <= {6'd0, mv};
          state <= SHIFT;
        end
`endif
        SHIFT: begin
          {bcd, bin} <= {bcd_adj[14:0], bin, 1'b0};
          cnt        <= cnt + 4'd1;
          if (cnt == 4'd15) state <= STORE;
        end
        STORE: begin
          done     <= 1'b1;
          sat      <= sat_q;
          err      <= ch_oob;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Port slots beyond CHANNELS are tied off so the fixed port list stays legal.
  generate
    for (genvar c = 0; c < NUM_PORTS; c++) begin : g_ch
      if (c < CHANNELS) begin : g_reg
        bin2bcd_chan_reg u_reg (
          .clk (clk),
          .rst (rst),
          .we  (wr_en && (ch_q == 4'(c))),
          .d   (bcd),
          .q   (bank[c])
        );
      end else begin : g_nc
        assign bank[c] = '0;
      end
    end
  endgenerate

  assign out0  = bank[0];
  assign out1  = bank[1];
  assign out2  = bank[2];
  assign out3  = bank[3];
  assign out4  = bank[4];
  assign out5  = bank[5];
  assign out6  = bank[6];
  assign out7  = bank[7];
  assign out8  = bank[8];
  assign out9  = bank[9];
  assign out10 = bank[10];
  assign out11 = bank[11];
  assign out12 = bank[12];
endmodule

// File: tb/tb_bin2bcd_channel_bank.sv
// Self-checking bench for bin2bcd_channel_bank against a decimal-arithmetic reference model.
// Honours BIN2BCD_SCALE_MV_EN for expected values and latency.

module tb_bin2bcd_channel_bank;
  logic        clk = 1'b0, rst = 1'b0, in_valid = 1'b0;
  logic [3:0]  in_ch = '0;
  logic [15:0] in_data = '0;
  logic        in_ready, done, sat, err;
  logic [15:0] out0, out1, out2, out3, out4, out5, out6, out7, out8, out9, out10, out11, out12;
  logic [15:0] outs [13];
  logic [15:0] exp_out [13];
  int checks = 0, errors = 0;

`ifdef BIN2BCD_SCALE_MV_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 17;
`endif

  bin2bcd_channel_bank dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
    .in_data(in_data), .done(done), .sat(sat), .err(err),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3), .out4(out4), .out5(out5),
    .out6(out6), .out7(out7), .out8(out8), .out9(out9), .out10(out10), .out11(out11),
    .out12(out12)
  );

  always #5 clk = ~clk;

  assign outs[0] = out0;   assign outs[1] = out1;   assign outs[2] = out2;
  assign outs[3] = out3;   assign outs[4] = out4;   assign outs[5] = out5;
  assign outs[6] = out6;   assign outs[7] = out7;   assign outs[8] = out8;
  assign outs[9] = out9;   assign outs[10] = out10; assign outs[11] = out11;
  assign outs[12] = out12;

  function automatic logic [15:0] to_bcd(input int v);
    return 16'((((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  function automatic int ref_val(input logic [15:0] d);
`ifdef BIN2BCD_SCALE_MV_EN
    return ((int'(d) / 16) * 1000) / 4096;
`else
    return (int'(d) > 9999) ? 9999 : int'(d);
`endif
  endfunction

  function automatic logic ref_sat(input logic [15:0] d);
`ifdef BIN2BCD_SCALE_MV_EN
    return 1'b0;
`else
    return int'(d) > 9999;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_outs(input string tag);
    for (int i = 0; i < 13; i++) chk($sformatf("%s_out%0d", tag, i), {16'd0, outs[i]}, {16'd0, exp_out[i]});
  endtask

  // Present a sample and return right after the edge that accepts it.
  task automatic start(input logic [3:0] ch, input logic [15:0] d);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1; in_ch = ch; in_data = d;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    chk("ready_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
  endtask

  // Follow one conversion from its accept edge; optionally keep in_valid up with the next sample.
  task automatic run(input logic [3:0] ch, input logic [15:0] d,
                     input bit keep, input logic [3:0] nch, input logic [15:0] nd);
    #1;
    if (keep) begin in_ch = nch; in_data = nd; end
    else begin in_valid = 1'b0; in_ch = 4'($urandom); in_data = 16'($urandom); end
    if (ch < 4'd13) exp_out[ch] = to_bcd(ref_val(d));
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); #1;
      if (k < LAT) begin
        chk($sformatf("busy_ready_c%0d", k), {31'd0, in_ready}, 32'd0);
        chk($sformatf("early_done_c%0d", k), {31'd0, done}, 32'd0);
      end else begin
        chk("done", {31'd0, done}, 32'd1);
        chk("sat", {31'd0, sat}, {31'd0, ref_sat(d)});
        chk("err", {31'd0, err}, {31'd0, ch >= 4'd13});
        chk("ready_back", {31'd0, in_ready}, 32'd1);
        chk_outs("store");
      end
    end
    @(posedge clk); #1;
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("reaccept", {31'd0, in_ready}, keep ? 32'd0 : 32'd1);
  endtask

  initial begin
    logic [3:0]  c0, c1;
    logic [15:0] d0, d1;
    for (int i = 0; i < 13; i++) exp_out[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_outs("reset");
    chk("reset_done", {29'd0, done, sat, err}, 32'd0);
    chk("reset_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Directed values, including saturation, add-3 boundaries and a bad channel.
    start(4'd3, 16'd1234);   run(4'd3, 16'd1234, 0, 0, 0);
    start(4'd0, 16'd12000);  run(4'd0, 16'd12000, 0, 0, 0);
    start(4'd12, 16'd0);     run(4'd12, 16'd0, 0, 0, 0);
    start(4'd12, 16'd9999);  run(4'd12, 16'd9999, 0, 0, 0);
    start(4'd1, 16'd5);      run(4'd1, 16'd5, 0, 0, 0);
    start(4'd1, 16'd50);     run(4'd1, 16'd50, 0, 0, 0);
    start(4'd1, 16'd500);    run(4'd1, 16'd500, 0, 0, 0);
    start(4'd1, 16'd5000);   run(4'd1, 16'd5000, 0, 0, 0);
    start(4'd13, 16'd42);    run(4'd13, 16'd42, 0, 0, 0);
    start(4'd2, 16'hFFF0);   run(4'd2, 16'hFFF0, 0, 0, 0);
    start(4'd4, 16'h8000);   run(4'd4, 16'h8000, 0, 0, 0);

    // in_valid held high: back-to-back accepts every LAT+1 cycles.
    c0 = 4'd6; d0 = 16'($urandom_range(0, 12000));
    start(c0, d0);
    for (int i = 0; i < 5; i++) begin
      c1 = 4'($urandom_range(0, 12));
      d1 = 16'($urandom_range(0, 12000));
      run(c0, d0, i < 4, c1, d1);
      c0 = c1; d0 = d1;
    end

    // Randomised samples across all channel indices and data ranges.
    for (int i = 0; i < 20; i++) begin
      c0 = 4'($urandom_range(0, 15));
      d0 = (i % 2 == 0) ? 16'($urandom_range(0, 9999)) : 16'($urandom);
      start(c0, d0);
      run(c0, d0, 0, 0, 0);
    end

    // Reset in the middle of a conversion to ch5 aborts it and clears the bank.
    start(4'd5, 16'd4321);   run(4'd5, 16'd4321, 0, 0, 0);
    start(4'd5, 16'd777);
    #1; in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1; rst = 1'b0;
    #1;
    for (int i = 0; i < 13; i++) exp_out[i] = '0;
    chk_outs("mid_rst");
    chk("mid_rst_flags", {28'd0, in_ready, done, sat, err}, 32'd0);
    @(negedge clk); rst = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    chk_outs("post_rst");
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_done", {31'd0, done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
